// File: rtl/wishbone_pkg.sv
// Shared state encoding and bus constants for the byte-stream Wishbone controller.
package wishbone_pkg;

  typedef enum logic [2:0] {
    CMD,
    ADR_HI,
    ADR_LO,
    DAT,
    BUS,
    RESP
  } wb_state_e;

  localparam logic [7:0]  WB_STATUS_OK      = 8'h00;
  localparam logic [7:0]  WB_STATUS_TIMEOUT = 8'hFF;
  localparam int unsigned WB_ADR_W          = 16;
  localparam int unsigned WB_DAT_W          = 32;

endpackage

// File: rtl/wishbone_byte_serializer.sv
// Sends the first i_count bytes of {status, data}, MSB first, over a valid/ready byte stream.
module wishbone_byte_serializer
  import wishbone_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8+WB_DAT_W-1:0] i_load,
  input  logic [2:0]            i_count,
  input  logic                  i_tx_ready,
  output logic                  o_tx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_done
);

  logic [8+WB_DAT_W-1:0] r_shift;
  logic [2:0]            r_left;
  logic                  r_valid;
  logic                  w_fire;

  assign w_fire     = r_valid && i_tx_ready;
  assign o_done     = w_fire && (r_left == 3'd1);
  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_shift[8+WB_DAT_W-1 -: 8];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_shift <= i_load;
      r_left  <= i_count;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      r_shift <= {r_shift[WB_DAT_W-1:0], 8'h00};
      r_left  <= r_left - 3'd1;
      if (r_left == 3'd1) r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wishbone_byte_controller.sv
// Byte-stream command decoder driving single-beat Wishbone cycles, with ack timeout and status reply.
module wishbone_byte_controller
  import wishbone_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic [7:0]          rx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  output logic [WB_ADR_W-1:0] wb_adr,
  output logic [3:0]          wb_sel,
  output logic [WB_DAT_W-1:0] wb_dat_c,
  input  logic [WB_DAT_W-1:0] wb_dat_p,
  input  logic                wb_ack
);

  localparam int unsigned       CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]     TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  wb_state_e             r_state;
  logic                  r_rx_ready;
  logic                  r_cyc;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [WB_ADR_W-1:0]   r_adr;
  logic [WB_DAT_W-1:0]   r_dat_c;
  logic [1:0]            r_byte_cnt;
  logic [CW-1:0]         r_wait;

  logic                  w_rx_fire;
  logic                  w_timeout;
  logic                  w_bus_end;
  logic                  w_tx_done;
  logic [8+WB_DAT_W-1:0] w_load;
  logic [2:0]            w_count;

  assign w_rx_fire = r_rx_ready && rx_valid;
  assign w_timeout = (r_wait == TO_LAST);
  // Ack takes priority over a simultaneous timeout.
  assign w_bus_end = (r_state == BUS) && (wb_ack || w_timeout);
  assign w_load    = {(wb_ack ? WB_STATUS_OK : WB_STATUS_TIMEOUT), wb_dat_p};
  assign w_count   = (wb_ack && !r_we) ? 3'd5 : 3'd1;

  assign rx_ready = r_rx_ready;
  assign wb_cyc   = r_cyc;
  assign wb_stb   = r_cyc;
  assign wb_we    = r_we;
  assign wb_adr   = r_adr;
  assign wb_sel   = r_sel;
  assign wb_dat_c = r_dat_c;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state    <= CMD;
      r_rx_ready <= 1'b0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_adr      <= '0;
      r_dat_c    <= '0;
      r_byte_cnt <= '0;
      r_wait     <= '0;
    end else begin
      case (r_state)
        CMD: begin
          r_rx_ready <= 1'b1;
          // Bytes with reserved bits set are swallowed so the stream can resync.
          if (w_rx_fire && (rx_data[6:4] == 3'b000)) begin
            r_we    <= rx_data[7];
            r_sel   <= rx_data[3:0];
            r_dat_c <= '0;
            r_state <= ADR_HI;
          end
        end
        ADR_HI: if (w_rx_fire) begin
          r_adr[15:8] <= rx_data;
          r_state     <= ADR_LO;
        end
        ADR_LO: if (w_rx_fire) begin
          r_adr[7:0] <= rx_data;
          r_byte_cnt <= '0;
          if (r_we) begin
            r_state <= DAT;
          end else begin
            r_cyc      <= 1'b1;
            r_rx_ready <= 1'b0;
            r_wait     <= '0;
            r_state    <= BUS;
          end
        end
        DAT: if (w_rx_fire) begin
          r_dat_c    <= {r_dat_c[WB_DAT_W-9:0], rx_data};
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_cyc      <= 1'b1;
            r_rx_ready <= 1'b0;
            r_wait     <= '0;
            r_state    <= BUS;
          end
        end
        BUS: begin
          if (w_bus_end) begin
            r_cyc   <= 1'b0;
            r_state <= RESP;
          end else if (!w_timeout) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        RESP: if (w_tx_done) begin
          r_rx_ready <= 1'b1;
          r_state    <= CMD;
        end
        default: r_state <= CMD;
      endcase
    end
  end

  wishbone_byte_serializer u_ser (
    .i_clk      (wb_clk),
    .i_rst      (wb_rst),
    .i_start    (w_bus_end),
    .i_load     (w_load),
    .i_count    (w_count),
    .i_tx_ready (tx_ready),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .o_done     (w_tx_done)
  );

endmodule
